serial_subtractor: RTL and testbench

Digit-serial ripple-borrow subtractor. It computes diff = a - b - bin over WIDTH bits, DIGIT bits per clock, and reports the final borrow. It is the subtract-direction counterpart of the datapath ripple adders. It trades latency for area and uses valid/ready handshakes on both the operand side and the result side.

---
 rtl/serial_subtractor_pkg.sv | 36 +++
 rtl/serial_subtractor_fs_digit.sv | 34 +++
 rtl/serial_subtractor.sv | 129 ++++++++++++
 tb/tb_serial_subtractor.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_pkg
// Description : Shared FSM state encoding and elaboration-time helpers for
//               the digit-serial ripple-borrow subtractor.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_subtractor_pkg;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Number of DIGIT-wide slices in a WIDTH-bit operand
    function automatic int num_digits(input int width, input int digit);
        return width / digit;
    endfunction

    // Ceiling log2, never less than 1 so a counter always has at least one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_fs_digit.sv
`default_nettype none
// ============================================================================
// Module      : fs_digit
// Description : Combinational DIGIT-bit ripple-borrow subtractor built from a
//               chain of 1-bit full subtractors: {bout_o, d_o} = a - b - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module fs_digit #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_dig_i,
    input  logic [DIGIT-1:0] b_dig_i,
    input  logic             bin_i,
    output logic [DIGIT-1:0] d_o,
    output logic             bout_o
);

    // w_borrow[i] is the borrow into bit i; w_borrow[DIGIT] leaves the digit
    logic [DIGIT:0] w_borrow;

    assign w_borrow[0] = bin_i;

    for (genvar i = 0; i < DIGIT; i++) begin : g_bit
        // Full subtractor: difference is the 3-way XOR; borrow when the
        // minuend bit is smaller than subtrahend bit plus incoming borrow
        assign d_o[i]          = a_dig_i[i] ^ b_dig_i[i] ^ w_borrow[i];
        assign w_borrow[i + 1] = (~a_dig_i[i] & b_dig_i[i])
                               | (~(a_dig_i[i] ^ b_dig_i[i]) & w_borrow[i]);
    end

    assign bout_o = w_borrow[DIGIT];

endmodule
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Digit-serial ripple-borrow subtractor. Computes
//               diff = (a - b - bin) mod 2^WIDTH, DIGIT bits per clock, with
//               valid/ready handshakes on operand and result sides.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int WIDTH = 22,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);

    localparam int             NUM_DIGITS = num_digits(WIDTH, DIGIT);
    localparam int             CNT_W      = clog2_min1(NUM_DIGITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

    // A partial last digit has no meaningful interpretation; refuse to build
    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("serial_subtractor: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
    end

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic             borrow_q;
    logic [WIDTH-1:0] diff_q;
    logic             bout_q;
    logic             out_valid_q;

    logic [DIGIT-1:0] dig_d;
    logic             borrow_d;
    logic [WIDTH-1:0] res_d;
    logic             w_accept;

    // One digit of the subtraction, fed from the bottom of the operand shifts
    fs_digit #(
        .DIGIT (DIGIT)
    ) u_fs_digit (
        .a_dig_i (a_sh_q[DIGIT-1:0]),
        .b_dig_i (b_sh_q[DIGIT-1:0]),
        .bin_i   (borrow_q),
        .d_o     (dig_d),
        .bout_o  (borrow_d)
    );

    // New digit enters at the top; after NUM_DIGITS shifts the LSD is at bit 0
    assign res_d = (res_q >> DIGIT) | (WIDTH'(dig_d) << (WIDTH - DIGIT));

    // Accepting in DONE needs the current result to be consumed on the same edge
    assign in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign w_accept = in_valid && in_ready;

    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign bout      = bout_q;

    // Controller, operand shift registers, result accumulation and output regs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            borrow_q    <= 1'b0;
            diff_q      <= '0;
            bout_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (w_accept) begin
            // Capture operands; any pending result is consumed by this edge
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            a_sh_q      <= a;
            b_sh_q      <= b;
            res_q       <= '0;
            borrow_q    <= bin;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_RUN: begin
                    a_sh_q   <= a_sh_q >> DIGIT;
                    b_sh_q   <= b_sh_q >> DIGIT;
                    res_q    <= res_d;
                    borrow_q <= borrow_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_q     <= ST_DONE;
                        diff_q      <= res_d;
                        bout_q      <= borrow_d;
                        out_valid_q <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // Result held until the consumer takes it
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor
// Description : Self-checking bench for serial_subtractor (DIGIT=1 and
//               DIGIT=11 instances) with directed and randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor;

    localparam int W = 22;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, bin, out_valid, out_ready, bout;
    logic [W-1:0] a, b, diff;

    logic         in_valid2, in_ready2, bin2, out_valid2, out_ready2, bout2;
    logic [W-1:0] a2, b2, diff2;

    int n_vec  = 0;
    int n_fail = 0;

    serial_subtractor #(.WIDTH(W), .DIGIT(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout)
    );

    serial_subtractor #(.WIDTH(W), .DIGIT(11)) dut11 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
        .diff(diff2), .bout(bout2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the unsigned operands
    function automatic logic [W-1:0] ref_diff(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                              input logic tbin);
        longint t;
        t = longint'(ta) - longint'(tb) - longint'(tbin);
        return t[W-1:0];
    endfunction

    function automatic logic ref_bout(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                      input logic tbin);
        return (longint'(ta) < (longint'(tb) + longint'(tbin)));
    endfunction

    // Called at posedge+1 right after the accept edge
    task automatic wait_result(input string tag, input logic [W-1:0] ed, input logic eb,
                               input bit chk_ready);
        int lat;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (chk_ready) check({tag, "_in_ready_run"}, in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 22);
        check({tag, "_diff"}, diff, ed);
        check({tag, "_bout"}, bout, eb);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tbin, input bit chk_ready);
        a = ta; b = tb; bin = tbin; in_valid = 1'b1;
        #1;
        check({tag, "_in_ready_accept"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        wait_result(tag, ref_diff(ta, tb, tbin), ref_bout(ta, tb, tbin), chk_ready);
    endtask

    initial begin
        logic [W-1:0] qd[$];
        logic         qb[$];
        logic [W-1:0] ra, rb;
        logic         rbin;
        bit           have;
        int           accepted, produced, cycles, lat2;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; bin = 1'b0;
        in_valid2 = 1'b0; out_ready2 = 1'b1; a2 = '0; b2 = '0; bin2 = 1'b0;
        #1;
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_diff", diff, 0);
        check("reset_bout", bout, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: basic subtraction, latency, in_ready low during RUN
        run_op("t1", 22'd5, 22'd3, 1'b0, 1'b1);
        check("t1_diff_abs", diff, 22'd2);
        @(posedge clk); #1;
        check("t1_consumed", out_valid, 0);

        // 2: wrap-around cases
        run_op("t2a", 22'd0, 22'd1, 1'b0, 1'b0);
        check("t2a_diff_abs", diff, 22'h3FFFFF);
        @(posedge clk); #1;
        run_op("t2b", 22'h3FFFFF, 22'h3FFFFF, 1'b1, 1'b0);
        check("t2b_bout_abs", bout, 1);
        @(posedge clk); #1;

        // 3: backpressure then same-edge consume + accept
        out_ready = 1'b0;
        run_op("t3a", 22'd100, 22'd58, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("t3_hold_valid", out_valid, 1);
            check("t3_hold_diff", diff, 22'd42);
            check("t3_hold_bout", bout, 0);
            check("t3_hold_in_ready", in_ready, 0);
        end
        a = 22'd7; b = 22'd9; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("t3_b2b_in_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t3_b2b_out_valid_drop", out_valid, 0);
        wait_result("t3b", 22'h3FFFFE, 1'b1, 1'b1);
        @(posedge clk); #1;

        // 4: reset during RUN aborts the operation
        a = 22'd1000; b = 22'd1; bin = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("t4_rst_out_valid", out_valid, 0);
        check("t4_rst_diff", diff, 0);
        check("t4_rst_bout", bout, 0);
        check("t4_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("t4_rst_hold_valid", out_valid, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        run_op("t4", 22'd1000, 22'd1, 1'b0, 1'b0);
        check("t4_diff_abs", diff, 22'd999);
        @(posedge clk); #1;

        // 5: DIGIT=11 instance, two-cycle latency
        a2 = 22'h200000; b2 = 22'd1; bin2 = 1'b0; in_valid2 = 1'b1;
        #1;
        check("t5_in_ready", in_ready2, 1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        lat2 = 0;
        while (!out_valid2 && lat2 < 20) begin
            @(posedge clk); #1;
            lat2++;
        end
        check("t5_latency", lat2, 2);
        check("t5_diff", diff2, 22'h1FFFFF);
        check("t5_bout", bout2, 0);

        // 6: random traffic against a scoreboard
        have = 1'b0; accepted = 0; produced = 0; cycles = 0;
        ra = '0; rb = '0; rbin = 1'b0;
        while ((accepted < 1000 || qd.size() > 0) && cycles < 80000) begin
            if (!have && accepted < 1000 && $urandom_range(0, 3) != 0) begin
                ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
                have = 1'b1;
            end
            in_valid = have; a = ra; b = rb; bin = rbin;
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (qd.size() == 0) begin
                    check("rnd_unexpected_result", qd.size(), 1);
                end else begin
                    check("rnd_diff", diff, qd[0]);
                    check("rnd_bout", bout, qb[0]);
                    void'(qd.pop_front());
                    void'(qb.pop_front());
                    produced++;
                end
            end
            if (in_valid && in_ready) begin
                qd.push_back(ref_diff(ra, rb, rbin));
                qb.push_back(ref_bout(ra, rb, rbin));
                accepted++;
                have = 1'b0;
            end
            @(posedge clk); #1;
            cycles++;
        end
        in_valid = 1'b0;
        check("rnd_results", produced, 1000);
        check("rnd_pending", qd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
